core_seq_ctrl: RTL
==================

// Module: core_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for the RV64I core: steps if/id/exe/regfile through FETCH, DECODE, EXECUTE, WRITEBACK.
//  Owns the PC, the instruction-memory request handshake, the instruction register and the regfile write strobe.
//  Adds halt, fetch-timeout error and retire counting. Sits between instruction memory and id_stage/regfile in rvcpu.
// PARAMETERS
//  PC_RESET       64'h0000_0000_8000_0000  PC loaded on reset
//  FETCH_TIMEOUT  16                       max FETCH cycles without inst_valid before error (>=1)
// PORTS
//  clk            in   1   core clock, all state on rising edge
//  rst            in   1   asynchronous, active-high reset
//  inst_ena       out  1   instruction fetch request, held until inst_valid
//  inst_addr      out  64  fetch address (= PC)
//  inst_valid     in   1   memory returns inst_rdata this cycle
//  inst_rdata     in   32  fetched instruction
//  ir             out  32  latched instruction to id_stage
//  dec_rd_w_ena   in   1   rd write enable decoded by id_stage
//  wb_ena         out  1   gated write enable to regfile
//  branch_taken   in   1   exe_stage redirect, sampled in WRITEBACK
//  branch_target  in   64  redirect target, sampled in WRITEBACK
//  halt_req       in   1   stop after current instruction retires
//  halted         out  1   core stopped (HALT state)
//  fetch_err      out  1   sticky: fetch timeout or misaligned target
//  retire_cnt     out  64  instructions retired, wraps modulo 2^64
//  state_o        out  3   current FSM state (debug)
// BEHAVIOUR
//  Reset (async): state=IDLE, pc=PC_RESET, ir=32'h0000_0013 (NOP), inst_ena=0, wb_ena=0, halted=0,
//   fetch_err=0, retire_cnt=0, timeout counter=0. Reset mid-instruction abandons it; no write issued.
//  States: IDLE->FETCH (1 cycle after reset release, unconditional).
//   FETCH: inst_ena=1, inst_addr=pc. inst_valid=1 -> ir<=inst_rdata, go DECODE. Counter +1 per waiting
//    cycle; reaching FETCH_TIMEOUT without inst_valid -> ERR. inst_valid in same cycle as limit wins.
//   DECODE: 1 cycle, inst_ena=0, ir stable -> EXECUTE.
//   EXECUTE: 1 cycle -> WRITEBACK.
//   WRITEBACK: 1 cycle; wb_ena=dec_rd_w_ena (combinational, only here); retire_cnt+1;
//    pc <= branch_taken ? branch_target : pc+4 (64-bit wrap). If branch_taken and target[1:0]!=0 -> ERR,
//    pc unchanged, instruction still counted. Else halt_req=1 -> HALT, otherwise -> FETCH.
//   HALT: halted=1, inst_ena=0, wb_ena=0; terminal until reset.
//   ERR: fetch_err=1, inst_ena=0, wb_ena=0; terminal until reset.
//  halt_req outside WRITEBACK is ignored (level must be held to WRITEBACK to take effect).
//  inst_valid outside FETCH ignored; ir changes only on FETCH acceptance.
//  Latency: zero-wait memory (inst_valid with first inst_ena cycle) -> 4 cycles/instruction; +1 per wait cycle.
//  inst_addr always equals pc register (registered, glitch-free); counter clears on entering FETCH.
// STRUCTURE
//  Shared defines: state encodings (IDLE=0,FETCH=1,DECODE=2,EXECUTE=3,WRITEBACK=4,HALT=5,ERR=6),
//   INST_NOP 32'h0000_0013, PC_RESET default, `REG_BUS width.
//  One sub-module: core_seq_timer (clearable up-counter with terminal flag) for fetch timeout.
//  FSM, pc, ir, retire_cnt live in this module; wb_ena/inst_ena decoded from state.
// TESTING
//  Zero-wait memory, 3 ADDI words at 0x8000_0000 -> inst_addr 0x8000_0000/04/08, wb_ena once per 4 cycles, retire_cnt=3.
//  inst_valid delayed 5 cycles -> inst_ena held 6 cycles, ir unchanged until accept, no wb_ena early.
//  inst_valid never asserts, FETCH_TIMEOUT=16 -> fetch_err=1 after 16 FETCH cycles, inst_ena=0 thereafter.
//  branch_taken=1, target 0x8000_0100 in WRITEBACK -> next inst_addr=0x8000_0100; target 0x8000_0102 -> ERR, pc held.
//  halt_req pulsed in DECODE only -> no halt; held through WRITEBACK -> halted=1, retire_cnt includes that instruction.
//  rst asserted mid-EXECUTE -> all outputs to reset values same cycle, wb_ena never pulses, restart at PC_RESET.

Source files
------------

// File: rtl/core_seq_ctrl_pkg.sv
// Shared definitions for the multi-cycle core sequencer: state encodings,
// the NOP instruction word and the default reset PC.
package core_seq_ctrl_pkg;

    localparam int REG_BUS = 64;

    localparam logic [31:0]        INST_NOP     = 32'h0000_0013;
    localparam logic [REG_BUS-1:0] PC_RESET_DEF = 64'h0000_0000_8000_0000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5,
        ST_ERR       = 3'd6
    } seq_state_t;

endpackage

// File: rtl/core_seq_timer.sv
// Clearable up-counter that raises term_o once LIMIT-1 enabled cycles have
// elapsed, so the LIMIT-th waiting cycle is the one that sees the flag.
module core_seq_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic term_o
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] TERM_CNT = W'(LIMIT - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign term_o = (count_q == TERM_CNT);

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && !term_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle sequencer for the RV64I core: owns PC, instruction register,
// fetch handshake, regfile write strobe, halt/error states and retire count.
module core_seq_ctrl
    import core_seq_ctrl_pkg::*;
#(
    parameter logic [REG_BUS-1:0] PC_RESET      = PC_RESET_DEF,
    parameter int                 FETCH_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    output logic               inst_ena,
    output logic [REG_BUS-1:0] inst_addr,
    input  logic               inst_valid,
    input  logic [31:0]        inst_rdata,
    output logic [31:0]        ir,
    input  logic               dec_rd_w_ena,
    output logic               wb_ena,
    input  logic               branch_taken,
    input  logic [REG_BUS-1:0] branch_target,
    input  logic               halt_req,
    output logic               halted,
    output logic               fetch_err,
    output logic [63:0]        retire_cnt,
    output logic [2:0]         state_o
);

    seq_state_t         state_q, state_d;
    logic [REG_BUS-1:0] pc_q, pc_d;
    logic [31:0]        ir_q, ir_d;
    logic [63:0]        retire_q, retire_d;
    logic               tmr_term;

    core_seq_timer #(
        .LIMIT (FETCH_TIMEOUT)
    ) u_fetch_timer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q != ST_FETCH),
        .en_i   ((state_q == ST_FETCH) && !inst_valid),
        .term_o (tmr_term)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        retire_d = retire_q;
        case (state_q)
            ST_IDLE:    state_d = ST_FETCH;
            ST_FETCH: begin
                // A response arriving on the limit cycle still counts as a fetch.
                if (inst_valid) begin
                    ir_d    = inst_rdata;
                    state_d = ST_DECODE;
                end else if (tmr_term) begin
                    state_d = ST_ERR;
                end
            end
            ST_DECODE:  state_d = ST_EXECUTE;
            ST_EXECUTE: state_d = ST_WRITEBACK;
            ST_WRITEBACK: begin
                retire_d = retire_q + 64'd1;
                if (branch_taken && (branch_target[1:0] != 2'b00)) begin
                    state_d = ST_ERR;
                end else begin
                    pc_d    = branch_taken ? branch_target : pc_q + 64'd4;
                    state_d = halt_req ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT:    state_d = ST_HALT;
            ST_ERR:     state_d = ST_ERR;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= PC_RESET;
            ir_q     <= INST_NOP;
            retire_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            retire_q <= retire_d;
        end
    end

    // ERR and HALT are terminal, so decoding them from state keeps the flags sticky.
    assign inst_ena   = (state_q == ST_FETCH);
    assign inst_addr  = pc_q;
    assign ir         = ir_q;
    assign wb_ena     = (state_q == ST_WRITEBACK) && dec_rd_w_ena;
    assign halted     = (state_q == ST_HALT);
    assign fetch_err  = (state_q == ST_ERR);
    assign retire_cnt = retire_q;
    assign state_o    = state_q;

endmodule
